// File: rtl/instr_encode_loader.sv
// Packs MIPS R/I-type fields into 32-bit words and writes them to sequential instruction-memory addresses.
// One cycle from accepted bundle to imWe; inReady is high only in LOAD and drops during a start pulse.
module instr_encode_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              inValid,
  output logic              inReady,
  input  logic              inLast,
  input  logic [5:0]        inOpcode,
  input  logic [4:0]        inRs,
  input  logic [4:0]        inRt,
  input  logic [4:0]        inRd,
  input  logic [4:0]        inShamt,
  input  logic [5:0]        inFunct,
  input  logic [15:0]       inImm,
  output logic              imWe,
  output logic [ADDR_W-1:0] imAddr,
  output logic [31:0]       imWData,
  output logic [ADDR_W:0]   wordCount,
  output logic              busy,
  output logic              done,
  output logic              errIllegal,
  output logic              errOverflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_ill_q, err_ill_d;
  logic                err_ovf_q, err_ovf_d;

  logic                in_ready;
  logic                accept;
  logic                legal;
  logic                full;
  logic [31:0]         enc_word;

  // A start in the same cycle as a valid bundle takes priority, so ready is masked by it.
  assign in_ready = (state_q == S_LOAD) && !start;
  assign accept   = inValid && in_ready;
  assign full     = (count_q >= DEPTH_C);

  always_comb begin
    legal = 1'b0;
    case (inOpcode)
      6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
  end

  always_comb begin
    enc_word = {inOpcode, inRs, inRt, inImm};
    if (inOpcode == 6'h00) begin
      enc_word = {inOpcode, inRs, inRt, inRd, inShamt, inFunct};
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    err_ill_d = err_ill_q;
    err_ovf_d = err_ovf_q;

    if (start) begin
      state_d   = S_LOAD;
      addr_d    = '0;
      count_d   = '0;
      err_ill_d = 1'b0;
      err_ovf_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (full) begin
              err_ovf_d = 1'b1;
            end else if (!legal) begin
              err_ill_d = 1'b1;
            end else begin
              // count_q < DEPTH here, so the address slice never wraps.
              we_d    = 1'b1;
              addr_d  = count_q[ADDR_W-1:0];
              wdata_d = enc_word;
              count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (inLast) begin
              state_d = S_FLUSH;
            end
          end
        end
        S_FLUSH: state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_ill_q <= err_ill_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign inReady     = in_ready;
  assign imWe        = we_q;
  assign imAddr      = addr_q;
  assign imWData     = wdata_q;
  assign wordCount   = count_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign errIllegal  = err_ill_q;
  assign errOverflow = err_ovf_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a full-size instance plus a DEPTH=4 instance sharing the stimulus.
module tb_instr_encode_loader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        inValid;
  logic        inLast;
  logic [5:0]  inOpcode;
  logic [4:0]  inRs, inRt, inRd, inShamt;
  logic [5:0]  inFunct;
  logic [15:0] inImm;

  logic        inReady, imWe, busy, done, errIllegal, errOverflow;
  logic [7:0]  imAddr;
  logic [31:0] imWData;
  logic [8:0]  wordCount;

  logic        inReady4, imWe4, busy4, done4, errIllegal4, errOverflow4;
  logic [1:0]  imAddr4;
  logic [31:0] imWData4;
  logic [2:0]  wordCount4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] log_addr[$], log_data[$];
  int          log_cyc[$];
  logic [31:0] log4_addr[$], log4_data[$];

  instr_encode_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .inValid(inValid), .inReady(inReady), .inLast(inLast),
    .inOpcode(inOpcode), .inRs(inRs), .inRt(inRt), .inRd(inRd), .inShamt(inShamt), .inFunct(inFunct),
    .inImm(inImm), .imWe(imWe), .imAddr(imAddr), .imWData(imWData), .wordCount(wordCount),
    .busy(busy), .done(done), .errIllegal(errIllegal), .errOverflow(errOverflow)
  );

  instr_encode_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .rstn(rstn), .start(start), .inValid(inValid), .inReady(inReady4), .inLast(inLast),
    .inOpcode(inOpcode), .inRs(inRs), .inRt(inRt), .inRd(inRd), .inShamt(inShamt), .inFunct(inFunct),
    .inImm(inImm), .imWe(imWe4), .imAddr(imAddr4), .imWData(imWData4), .wordCount(wordCount4),
    .busy(busy4), .done(done4), .errIllegal(errIllegal4), .errOverflow(errOverflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imWe) begin
      log_addr.push_back({24'd0, imAddr});
      log_data.push_back(imWData);
      log_cyc.push_back(cyc);
    end
    if (imWe4) begin
      log4_addr.push_back({30'd0, imAddr4});
      log4_data.push_back(imWData4);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    log4_addr.delete(); log4_data.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Presents one bundle and returns 1 time unit after the edge that accepts it.
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic last);
    bit ok;
    inOpcode = op; inRs = rs; inRt = rt; inRd = rd; inShamt = sh; inFunct = fn;
    inImm = imm; inLast = last; inValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (inReady) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; inValid = 1'b0; inLast = 1'b0;
    inOpcode = '0; inRs = '0; inRt = '0; inRd = '0; inShamt = '0; inFunct = '0; inImm = '0;

    // Reset state
    #2;
    chk("rst_inReady",   {31'd0, inReady}, 32'd0);
    chk("rst_imWe",      {31'd0, imWe}, 32'd0);
    chk("rst_wordCount", {23'd0, wordCount}, 32'd0);
    chk("rst_flags",     {28'd0, busy, done, errIllegal, errOverflow}, 32'd0);
    idle_cycles(2);
    rstn = 1'b1;
    idle_cycles(1);

    // 1) single ADDI with last
    clear_logs();
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 1'b1);
    inValid = 1'b0; inLast = 1'b0;
    chk("t1_imWe_next", {31'd0, imWe}, 32'd1);
    idle_cycles(3);
    chk("t1_nwrites", log_addr.size(), 32'd1);
    if (log_addr.size() == 1) begin
      chk("t1_addr", log_addr[0], 32'd0);
      chk("t1_data", log_data[0], 32'h20220005);
    end
    chk("t1_done",      {31'd0, done}, 32'd1);
    chk("t1_busy_off",  {31'd0, busy}, 32'd0);
    chk("t1_wordCount", {23'd0, wordCount}, 32'd1);
    chk("t1_ready_off", {31'd0, inReady}, 32'd0);

    // 2) R-type then ORI back to back
    clear_logs();
    pulse_start();
    send(6'h00, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20, 16'h0000, 1'b0);
    send(6'h0D, 5'd0, 5'd6, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1);
    inValid = 1'b0; inLast = 1'b0;
    idle_cycles(3);
    chk("t2_nwrites", log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      chk("t2_addr0", log_addr[0], 32'd0);
      chk("t2_data0", log_data[0], 32'h00642820);
      chk("t2_addr1", log_addr[1], 32'd1);
      chk("t2_data1", log_data[1], 32'h3406FFFF);
      chk("t2_b2b",   log_cyc[1] - log_cyc[0], 32'd1);
    end
    chk("t2_wordCount", {23'd0, wordCount}, 32'd2);
    chk("t2_errIllegal", {31'd0, errIllegal}, 32'd0);

    // 3) illegal J opcode mid-stream
    clear_logs();
    pulse_start();
    send(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0001, 1'b0);
    send(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h1234, 1'b0);
    send(6'h23, 5'd7, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0010, 1'b1);
    inValid = 1'b0; inLast = 1'b0;
    idle_cycles(3);
    chk("t3_nwrites", log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      chk("t3_addr1", log_addr[1], 32'd1);
      chk("t3_data1", log_data[1], 32'h8CE80010);
    end
    chk("t3_errIllegal", {31'd0, errIllegal}, 32'd1);
    chk("t3_wordCount",  {23'd0, wordCount}, 32'd2);
    chk("t3_done",       {31'd0, done}, 32'd1);

    // 4) overflow on the DEPTH=4 instance
    clear_logs();
    pulse_start();
    chk("t4_errIllegal_clr", {31'd0, errIllegal4}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i), (i == 4));
    end
    inValid = 1'b0; inLast = 1'b0;
    idle_cycles(3);
    chk("t4_nwrites", log4_addr.size(), 32'd4);
    if (log4_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4_addr", log4_addr[i], 32'(i));
        chk("t4_data", log4_data[i], 32'h20220000 | 32'(i));
      end
    end
    chk("t4_errOverflow", {31'd0, errOverflow4}, 32'd1);
    chk("t4_wordCount",   {29'd0, wordCount4}, 32'd4);
    chk("t4_done",        {31'd0, done4}, 32'd1);

    // 6) start in DONE with inValid held high
    clear_logs();
    inOpcode = 6'h0D; inRs = 5'd0; inRt = 5'd6; inImm = 16'hFFFF; inLast = 1'b1; inValid = 1'b1;
    idle_cycles(2);
    chk("t6_ignored", log_addr.size(), 32'd0);
    start = 1'b1;
    @(negedge clk);
    chk("t6_ready_start", {31'd0, inReady}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_count_clr", {23'd0, wordCount}, 32'd0);
    chk("t6_flags_clr", {29'd0, done4, errIllegal4, errOverflow4}, 32'd0);
    @(posedge clk); #1;
    inValid = 1'b0; inLast = 1'b0;
    idle_cycles(3);
    chk("t6_nwrites", log_addr.size(), 32'd1);
    if (log_addr.size() == 1) begin
      chk("t6_addr", log_addr[0], 32'd0);
      chk("t6_data", log_data[0], 32'h3406FFFF);
    end
    chk("t6_done", {31'd0, done}, 32'd1);

    // 5) reset dropped while streaming
    pulse_start();
    inOpcode = 6'h09; inRs = 5'd1; inRt = 5'd1; inImm = 16'h00AA; inLast = 1'b0; inValid = 1'b1;
    idle_cycles(3);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_imWe",    {31'd0, imWe}, 32'd0);
    chk("t5_imAddr",  {24'd0, imAddr}, 32'd0);
    chk("t5_imWData", imWData, 32'd0);
    chk("t5_count",   {23'd0, wordCount}, 32'd0);
    chk("t5_flags",   {27'd0, inReady, busy, done, errIllegal, errOverflow}, 32'd0);
    clear_logs();
    idle_cycles(2);
    rstn = 1'b1;
    idle_cycles(5);
    chk("t5_nowrite", log_addr.size(), 32'd0);
    chk("t5_ready",   {31'd0, inReady}, 32'd0);
    inValid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
